// File: rtl/dmem_watch_arbiter_if.sv
// dmem_watch_arbiter_if
// Bundles the three buses around the data-memory arbiter:
//   cpu_*   : MEM-stage request, grant and load-return path
//   mem_*   : single-port data RAM access port (1-cycle read latency)
//   watch_* : debug scanner control and captured display word
// Modports:
//   slave  : the arbiter's view (takes CPU/scanner requests and RAM data, drives the rest)
//   master : the surrounding system's view (pipeline, RAM and display side)
interface dmem_watch_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [3:0]        cpu_be;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              watch_tick;
  logic              watch_en;
  logic [ADDR_W-1:0] watch_addr;
  logic [DATA_W-1:0] watch_data;
  logic              watch_valid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  watch_tick, watch_en,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output watch_addr, watch_data, watch_valid,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output watch_tick, watch_en,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  watch_addr, watch_data, watch_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dmem_watch_arbiter.sv
// dmem_watch_arbiter
// Shares the single-port data RAM between the pipeline MEM stage and the debug
// watch scanner feeding the 7-segment memory view. The CPU wins by default; a
// pending watch read is forced through after STARVE_LIMIT consecutive CPU wins,
// stalling the CPU for that one cycle.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : dmem_watch_arbiter_if.slave
//            cpu_*   request/grant (grant is combinational), load return one cycle later
//            mem_*   combinational RAM access port, mem_rdata has 1-cycle latency
//            watch_* scan tick/enable in, captured word/address/valid pulse out
module dmem_watch_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WATCH_WORDS  = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_watch_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(WATCH_WORDS * 4);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FLIGHT
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  watch_ptr;
  logic [CNT_W-1:0]  starve_cnt;
  logic              cpu_rvalid_q;
  logic              watch_valid_q;
  logic [ADDR_W-1:0] watch_addr_q;
  logic [DATA_W-1:0] watch_data_q;

  logic watch_req;
  logic watch_issue;
  logic cpu_gnt;
  logic cpu_store;

  // The watch read goes out on the first free cycle while pending, or is forced
  // once the CPU has won STARVE_LIMIT times in a row. Dropping watch_en while
  // pending cancels the read in the same cycle, so the CPU is never stalled then.
  assign watch_req   = bus.watch_tick & bus.watch_en;
  assign watch_issue = (state == PEND) && bus.watch_en &&
                       (!bus.cpu_req || (starve_cnt == CNT_W'(STARVE_LIMIT)));
  assign cpu_gnt     = bus.cpu_req & ~watch_issue;
  assign cpu_store   = cpu_gnt & bus.cpu_we;

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.mem_en    = cpu_gnt | watch_issue;
  assign bus.mem_we    = cpu_store;
  assign bus.mem_addr  = watch_issue ? ADDR_W'(watch_ptr) : bus.cpu_addr;
  assign bus.mem_wdata = bus.cpu_wdata;
  assign bus.mem_be    = cpu_store ? bus.cpu_be : 4'b0000;

  // The CPU tag is cpu_rvalid itself; returned data is only passed through
  // while it is set so a stale RAM word never leaks onto cpu_rdata.
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.cpu_rdata   = cpu_rvalid_q ? bus.mem_rdata : '0;
  assign bus.watch_valid = watch_valid_q;
  assign bus.watch_addr  = watch_addr_q;
  assign bus.watch_data  = watch_data_q;

  // FLIGHT is the cycle in which the RAM returns the watch word; the capture,
  // the displayed address and the pointer advance all happen at its end.
  // A tick seen during FLIGHT re-arms the scanner straight away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      watch_ptr     <= '0;
      starve_cnt    <= '0;
      cpu_rvalid_q  <= 1'b0;
      watch_valid_q <= 1'b0;
      watch_addr_q  <= '0;
      watch_data_q  <= '0;
    end else begin
      cpu_rvalid_q  <= cpu_gnt & ~bus.cpu_we;
      watch_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (watch_req) begin
            state      <= PEND;
            starve_cnt <= '0;
          end
        end
        PEND: begin
          if (!bus.watch_en) begin
            state <= IDLE;
          end else if (watch_issue) begin
            state <= FLIGHT;
          end else begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        FLIGHT: begin
          watch_data_q  <= bus.mem_rdata;
          watch_addr_q  <= ADDR_W'(watch_ptr);
          watch_valid_q <= 1'b1;
          watch_ptr     <= watch_ptr + PTR_W'(4);
          starve_cnt    <= '0;
          state         <= watch_req ? PEND : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_watch_arbiter.sv
// tb_dmem_watch_arbiter
// Directed scenarios followed by randomized CPU traffic around watch reads.
// A small byte-enabled RAM with 1-cycle read latency sits on the mem_* port.
// Expected values come from a shadow memory plus the arbitration rule stated
// at transaction level: the watch read goes on the first idle CPU cycle after
// the tick, or after STARVE_LIMIT CPU wins; its word appears two cycles later.
module tb_dmem_watch_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int WATCH_WORDS  = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int SPAN         = WATCH_WORDS * 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_watch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_watch_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .WATCH_WORDS(WATCH_WORDS),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [31:0] initWord(input int i);
    if (i == 1) return 32'hDEADBEEF;
    return 32'hA5000000 | (32'(i) * 32'h00010101);
  endfunction

  logic [31:0] ram [0:15];
  logic [31:0] ramRdata;
  assign bus.mem_rdata = ramRdata;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= initWord(i);
      ramRdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) ram[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      ramRdata <= ram[bus.mem_addr[5:2]];
    end
  end

  int nChecks;
  int nFails;
  logic [31:0] shadow [0:15];
  int wptr;

  logic        rq   [0:11];
  logic        wr   [0:11];
  logic [31:0] ad   [0:11];
  logic [31:0] wd   [0:11];
  logic [3:0]  bev  [0:11];
  logic        prevG;
  logic [31:0] prevData;
  logic [31:0] expW;
  logic        g;
  logic        tk;
  int          j;

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic tick, input logic en);
    @(negedge clk);
    bus.cpu_req    = req;
    bus.cpu_we     = we;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wdata;
    bus.cpu_be     = be;
    bus.watch_tick = tick;
    bus.watch_en   = en;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idleCycle(input logic tick, input logic en);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, tick, en);
  endtask

  // One watch read with an idle CPU: tick, issue, return, display.
  task automatic watchIdleRead(input string tag);
    idleCycle(1'b1, 1'b1);
    idleCycle(1'b0, 1'b1);
    checkOutput({tag, "_mem_en"}, 32'(bus.mem_en), 32'd1);
    checkOutput({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 32'(wptr));
    checkOutput({tag, "_mem_be"}, 32'(bus.mem_be), 32'd0);
    idleCycle(1'b0, 1'b1);
    checkOutput({tag, "_early_valid"}, 32'(bus.watch_valid), 32'd0);
    idleCycle(1'b0, 1'b1);
    checkOutput({tag, "_valid"}, 32'(bus.watch_valid), 32'd1);
    checkOutput({tag, "_addr"}, bus.watch_addr, 32'(wptr));
    checkOutput({tag, "_data"}, bus.watch_data, shadow[wptr/4]);
    idleCycle(1'b0, 1'b1);
    checkOutput({tag, "_pulse_end"}, 32'(bus.watch_valid), 32'd0);
    wptr = (wptr + 4) % SPAN;
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    wptr    = 0;
    reset   = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cpu_be = '0; bus.watch_tick = 1'b0; bus.watch_en = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = initWord(i);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_gnt", 32'(bus.cpu_gnt), 32'd0);
    checkOutput("rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    checkOutput("rst_wvalid", 32'(bus.watch_valid), 32'd0);
    checkOutput("rst_waddr", bus.watch_addr, 32'd0);
    checkOutput("rst_wdata", bus.watch_data, 32'd0);
    checkOutput("rst_mem_en", 32'(bus.mem_en), 32'd0);
    reset = 1'b0;

    // Reset asserted while the watch word is in flight, with a CPU load granted.
    idleCycle(1'b1, 1'b1);
    idleCycle(1'b0, 1'b1);
    checkOutput("t1_issue", 32'(bus.mem_en), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1);
    checkOutput("t1_flight_gnt", 32'(bus.cpu_gnt), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t1_rst_wvalid", 32'(bus.watch_valid), 32'd0);
    checkOutput("t1_rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    checkOutput("t1_rst_rdata", bus.cpu_rdata, 32'd0);
    checkOutput("t1_rst_waddr", bus.watch_addr, 32'd0);
    checkOutput("t1_rst_wdata", bus.watch_data, 32'd0);
    idleCycle(1'b0, 1'b0);
    idleCycle(1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idleCycle(1'b0, 1'b0);
      checkOutput("t1_post_wvalid", 32'(bus.watch_valid), 32'd0);
      checkOutput("t1_post_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      checkOutput("t1_post_waddr", bus.watch_addr, 32'd0);
    end

    // Idle CPU: reads at 0x0 then 0x4 (0xDEADBEEF).
    watchIdleRead("t2_w0");
    watchIdleRead("t2_w1");
    checkOutput("t2_deadbeef", bus.watch_data, 32'hDEADBEEF);

    // Store at 0x8, watch read of the same word in the next cycle.
    applyStimulus(1'b1, 1'b1, 32'h8, 32'h12345678, 4'hF, 1'b1, 1'b1);
    checkOutput("t5_st_gnt", 32'(bus.cpu_gnt), 32'd1);
    checkOutput("t5_st_we", 32'(bus.mem_we), 32'd1);
    checkOutput("t5_st_be", 32'(bus.mem_be), 32'hF);
    shadow[2] = 32'h12345678;
    idleCycle(1'b0, 1'b1);
    checkOutput("t5_rd_addr", bus.mem_addr, 32'h8);
    checkOutput("t5_rd_we", 32'(bus.mem_we), 32'd0);
    idleCycle(1'b0, 1'b1);
    idleCycle(1'b0, 1'b1);
    checkOutput("t5_valid", 32'(bus.watch_valid), 32'd1);
    checkOutput("t5_data", bus.watch_data, 32'h12345678);
    checkOutput("t5_addr", bus.watch_addr, 32'h8);
    wptr = (wptr + 4) % SPAN;

    // Wrap: 0xC then back to 0x0.
    watchIdleRead("t4_wC");
    watchIdleRead("t4_w0");

    // CPU loads every cycle: 8 grants while pending, then one forced stall.
    prevG = 1'b0;
    prevData = '0;
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      a = 32'h10 + 32'(4 * (i % 4));
      applyStimulus(1'b1, 1'b0, a, 32'h0, 4'h0, (i == 0), 1'b1);
      checkOutput("t3_gnt", 32'(bus.cpu_gnt), 32'(i != STARVE_LIMIT + 1));
      checkOutput("t3_rvalid", 32'(bus.cpu_rvalid), 32'(prevG));
      if (prevG) checkOutput("t3_rdata", bus.cpu_rdata, prevData);
      if (i == STARVE_LIMIT + 1) checkOutput("t3_force_addr", bus.mem_addr, 32'(wptr));
      checkOutput("t3_wvalid", 32'(bus.watch_valid), 32'(i == STARVE_LIMIT + 3));
      if (i == STARVE_LIMIT + 3) checkOutput("t3_wdata", bus.watch_data, shadow[wptr/4]);
      prevG = (i != STARVE_LIMIT + 1);
      prevData = shadow[a[5:2]];
    end
    wptr = (wptr + 4) % SPAN;

    // Tick, then watch_en dropped while pending under CPU load: no read, no stall.
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b1, 1'b1);
    checkOutput("t6_gnt0", 32'(bus.cpu_gnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h18, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("t6_gnt1", 32'(bus.cpu_gnt), 32'd1);
    checkOutput("t6_addr1", bus.mem_addr, 32'h18);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h1C, 32'h0, 4'h0, 1'b0, 1'b1);
      checkOutput("t6_gnt", 32'(bus.cpu_gnt), 32'd1);
      checkOutput("t6_wvalid", 32'(bus.watch_valid), 32'd0);
    end
    prevG = 1'b1;
    prevData = shadow[7];

    // Randomized CPU traffic around each watch read.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 12; i++) begin
        rq[i]  = (t % 5 == 4) ? 1'b1 : ($urandom_range(0, 9) < 7);
        wr[i]  = $urandom_range(0, 1) == 1;
        ad[i]  = 32'(4 * $urandom_range(0, 7));
        wd[i]  = $urandom;
        bev[i] = 4'($urandom_range(0, 15));
      end
      j = STARVE_LIMIT + 1;
      for (int i = STARVE_LIMIT; i >= 1; i--) if (!rq[i]) j = i;
      expW = '0;
      for (int i = 0; i <= j + 2; i++) begin
        tk = (i == 0) || ((i <= j) && ($urandom_range(0, 3) == 0));
        applyStimulus(rq[i], wr[i], ad[i], wd[i], bev[i], tk, 1'b1);
        g = rq[i] && (i != j);
        checkOutput("r_gnt", 32'(bus.cpu_gnt), 32'(g));
        checkOutput("r_rvalid", 32'(bus.cpu_rvalid), 32'(prevG));
        if (prevG) checkOutput("r_rdata", bus.cpu_rdata, prevData);
        if (i == j) begin
          checkOutput("r_waddr_issue", bus.mem_addr, 32'(wptr));
          checkOutput("r_watch_we", 32'(bus.mem_we), 32'd0);
          expW = shadow[wptr/4];
        end else if (g) begin
          checkOutput("r_cpu_addr", bus.mem_addr, ad[i]);
          checkOutput("r_cpu_be", 32'(bus.mem_be), wr[i] ? 32'(bev[i]) : 32'd0);
        end
        checkOutput("r_wvalid", 32'(bus.watch_valid), 32'(i == j + 2));
        if (i == j + 2) begin
          checkOutput("r_wa", bus.watch_addr, 32'(wptr));
          checkOutput("r_wd", bus.watch_data, expW);
        end
        prevG = g && !wr[i];
        prevData = shadow[ad[i][5:2]];
        if (g && wr[i]) begin
          for (int b = 0; b < 4; b++)
            if (bev[i][b]) shadow[ad[i][5:2]][8*b +: 8] = wd[i][8*b +: 8];
        end
      end
      wptr = (wptr + 4) % SPAN;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
